// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory store and load paths.
// Encodings, load window width and the queued store-entry layout.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } st_size_e;

   localparam int unsigned LOAD_BYTES = 8;

   // Entry address is sized for the widest supported ADDR_W; users keep the low bits.
   localparam int unsigned ST_ADDR_MAX_W = 16;

   typedef struct packed {
      logic [ST_ADDR_MAX_W-1:0] addr;
      logic [31:0]              data;
      logic [2:0]               nbytes;
   } st_entry_t;

   function automatic logic [2:0] size_to_nbytes(input logic [1:0] sz);
      case (sz)
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous store-request FIFO; exposes every slot plus a valid mask
// so the owner can scan pending stores for address overlap.
module store_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic                             push_i,
   input  st_entry_t                        push_data_i,
   input  logic                             pop_i,
   output st_entry_t                        head_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [$clog2(DEPTH+1)-1:0]       count_o,
   output st_entry_t [DEPTH-1:0]            entries_o,
   output logic [DEPTH-1:0]                 valid_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   st_entry_t [DEPTH-1:0] mem;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic                  do_push;
   logic                  do_pop;

   assign full_o    = (count == CNT_W'(DEPTH));
   assign empty_o   = (count == '0);
   assign count_o   = count;
   assign head_o    = mem[rd_ptr];
   assign entries_o = mem;
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_ff @(posedge clock_i) begin
      if (do_push) mem[wr_ptr] <= push_data_i;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      logic [PTR_W-1:0] rel;
      valid_o = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         rel        = PTR_W'(i) - rd_ptr;
         valid_o[i] = (CNT_W'(rel) < count);
      end
   end

endmodule

// File: rtl/dmem_store_unit.sv
// Write side of the byte-organised data memory: queues stores, drains them
// big-endian one byte per cycle, and flags loads that overlap pending stores.
module dmem_store_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [31:0]       st_data_i,
   input  logic [1:0]        st_size_i,
   output logic              st_err_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   input  logic [ADDR_W-1:0] chk_addr_i,
   output logic              chk_hit_o,
   output logic              empty_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   typedef enum logic {S_IDLE, S_WRITE} state_e;

   state_e                state_q, state_d;
   logic [1:0]            k_q, k_d;
   logic                  we_d, err_d;
   logic [ADDR_W-1:0]     addr_d;
   logic [7:0]            data_d;

   logic                  accept, push, pop;
   st_entry_t             push_entry, head;
   st_entry_t [DEPTH-1:0] fifo_entries;
   logic [DEPTH-1:0]      fifo_valid;
   logic                  fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic                  last_byte;
   logic [2:0]            sel_idx;
   logic [7:0]            byte_sel;
   logic                  unused_entry_bits;

   assign st_ready_o = !fifo_full;
   assign accept     = st_valid_i && st_ready_o;
   assign push       = accept && (st_size_i != SZ_BAD);
   assign err_d      = accept && (st_size_i == SZ_BAD);
   assign empty_o    = fifo_empty && !mem_we_o;

   assign push_entry.addr   = ST_ADDR_MAX_W'(st_addr_i);
   assign push_entry.data   = st_data_i;
   assign push_entry.nbytes = size_to_nbytes(st_size_i);

   store_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .entries_o   (fifo_entries),
      .valid_o     (fifo_valid)
   );

   assign unused_entry_bits = ^{head, fifo_entries};

   // Big-endian: byte k of an n-byte store is data byte (n-1-k) counted from the LSB.
   always_comb begin
      sel_idx   = head.nbytes - 3'd1 - {1'b0, k_q};
      last_byte = ({1'b0, k_q} == head.nbytes - 3'd1);
      case (sel_idx[1:0])
         2'd3:    byte_sel = head.data[31:24];
         2'd2:    byte_sel = head.data[23:16];
         2'd1:    byte_sel = head.data[15:8];
         default: byte_sel = head.data[7:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      we_d    = 1'b0;
      addr_d  = mem_addr_o;
      data_d  = mem_data_o;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_WRITE;
               k_d     = '0;
            end
         end
         S_WRITE: begin
            we_d   = 1'b1;
            addr_d = head.addr[ADDR_W-1:0] + ADDR_W'(k_q);
            data_d = byte_sel;
            if (last_byte) begin
               pop     = 1'b1;
               k_d     = '0;
               state_d = ((fifo_count > CNT_W'(1)) || push) ? S_WRITE : S_IDLE;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         st_err_o   <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         mem_we_o   <= we_d;
         mem_addr_o <= addr_d;
         mem_data_o <= data_d;
         st_err_o   <= err_d;
      end
   end

   function automatic logic overlaps(input logic [ADDR_W-1:0] a,
                                     input logic [2:0]        n,
                                     input logic [ADDR_W-1:0] base);
      logic [ADDR_W-1:0] fwd;
      logic [ADDR_W-1:0] back;
      fwd  = a - base;
      back = base - a;
      return (fwd < ADDR_W'(LOAD_BYTES)) || (back < ADDR_W'(n));
   endfunction

   always_comb begin
      chk_hit_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i] &&
             overlaps(fifo_entries[i].addr[ADDR_W-1:0], fifo_entries[i].nbytes, chk_addr_i))
            chk_hit_o = 1'b1;
      end
      if (mem_we_o && overlaps(mem_addr_o, 3'd1, chk_addr_i))
         chk_hit_o = 1'b1;
   end

endmodule

// File: tb/tb_dmem_store_unit.sv
// Directed bench for dmem_store_unit: hand-computed byte streams, overlap
// flag, illegal-size pulse and reset abandoning a partial store.
module tb_dmem_store_unit;

   logic       clock_i = 1'b0;
   logic       reset_i;
   logic       st_valid_i;
   logic       st_ready_o;
   logic [9:0] st_addr_i;
   logic [31:0] st_data_i;
   logic [1:0] st_size_i;
   logic       st_err_o;
   logic       mem_we_o;
   logic [9:0] mem_addr_o;
   logic [7:0] mem_data_o;
   logic [9:0] chk_addr_i;
   logic       chk_hit_o;
   logic       empty_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [9:0]  a;
      logic [7:0]  d;
      int unsigned cyc;
   } wr_t;

   wr_t         wq[$];
   int unsigned cyc = 0;

   always #5 clock_i = ~clock_i;

   dmem_store_unit #(.DEPTH(4), .ADDR_W(10)) dut (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .st_valid_i (st_valid_i),
      .st_ready_o (st_ready_o),
      .st_addr_i  (st_addr_i),
      .st_data_i  (st_data_i),
      .st_size_i  (st_size_i),
      .st_err_o   (st_err_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .chk_addr_i (chk_addr_i),
      .chk_hit_o  (chk_hit_o),
      .empty_o    (empty_o)
   );

   always @(posedge clock_i) cyc++;

   always @(negedge clock_i) begin
      if (mem_we_o) wq.push_back('{a: mem_addr_o, d: mem_data_o, cyc: cyc});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic exp_wr(input string tag, input int unsigned idx,
                         input logic [9:0] a, input logic [7:0] d);
      if (idx < wq.size()) begin
         check({tag, "_addr"}, 32'(wq[idx].a), 32'(a));
         check({tag, "_data"}, 32'(wq[idx].d), 32'(d));
      end else begin
         check({tag, "_missing"}, 32'(wq.size()), 32'(idx + 1));
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send(input logic [9:0] a, input logic [31:0] d, input logic [1:0] s);
      int unsigned n = 0;
      st_valid_i = 1'b1;
      st_addr_i  = a;
      st_data_i  = d;
      st_size_i  = s;
      while (!st_ready_o && n < 100) begin
         @(negedge clock_i);
         n++;
      end
      check("send_ready", 32'(st_ready_o), 32'd1);
      @(posedge clock_i);
      @(negedge clock_i);
      st_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while (!empty_o && n < 200) begin
         @(negedge clock_i);
         n++;
      end
      check({tag, "_idle"}, 32'(empty_o), 32'd1);
      #1;
   endtask

   task automatic wait_wr(input string tag, input logic [9:0] a);
      int unsigned n = 0;
      while (!(mem_we_o && mem_addr_o == a) && n < 100) begin
         @(negedge clock_i);
         n++;
      end
      check({tag, "_seen"}, 32'(mem_we_o && mem_addr_o == a), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int unsigned b;
      logic [31:0] wd;
      reset_i    = 1'b1;
      st_valid_i = 1'b0;
      st_addr_i  = '0;
      st_data_i  = '0;
      st_size_i  = 2'b00;
      chk_addr_i = '0;
      repeat (3) @(negedge clock_i);
      reset_i = 1'b0;
      @(negedge clock_i);

      // Reset state
      check("rst_ready", 32'(st_ready_o), 32'd1);
      check("rst_err",   32'(st_err_o),   32'd0);
      check("rst_we",    32'(mem_we_o),   32'd0);
      check("rst_addr",  32'(mem_addr_o), 32'd0);
      check("rst_data",  32'(mem_data_o), 32'd0);
      check("rst_hit",   32'(chk_hit_o),  32'd0);
      check("rst_empty", 32'(empty_o),    32'd1);

      // Single word store
      b = wq.size();
      send(10'h010, 32'hAABBCCDD, 2'b10);
      wait_idle("t1");
      check("t1_count", 32'(wq.size() - b), 32'd4);
      exp_wr("t1_b0", b + 0, 10'h010, 8'hAA);
      exp_wr("t1_b1", b + 1, 10'h011, 8'hBB);
      exp_wr("t1_b2", b + 2, 10'h012, 8'hCC);
      exp_wr("t1_b3", b + 3, 10'h013, 8'hDD);
      if (wq.size() >= b + 4) check("t1_span", wq[b+3].cyc - wq[b].cyc, 32'd3);

      // Wrapping half followed by a byte, no bubble
      b = wq.size();
      send(10'h3FF, 32'h00001234, 2'b01);
      send(10'h005, 32'h0000007F, 2'b00);
      wait_idle("t2");
      check("t2_count", 32'(wq.size() - b), 32'd3);
      exp_wr("t2_b0", b + 0, 10'h3FF, 8'h12);
      exp_wr("t2_b1", b + 1, 10'h000, 8'h34);
      exp_wr("t2_b2", b + 2, 10'h005, 8'h7F);
      if (wq.size() >= b + 3) check("t2_span", wq[b+2].cyc - wq[b].cyc, 32'd2);

      // Five words into a four-deep FIFO
      b = wq.size();
      for (int i = 0; i < 4; i++)
         send(10'(10'h100 + 4 * i), 32'h10203040 + 32'(i) * 32'h01010101, 2'b10);
      check("t3_full_ready", 32'(st_ready_o), 32'd0);
      send(10'h110, 32'h10203040 + 32'd4 * 32'h01010101, 2'b10);
      #1;
      check("t3_5th_after_pop", 32'(wq.size() - b >= 4), 32'd1);
      wait_idle("t3");
      check("t3_count", 32'(wq.size() - b), 32'd20);
      for (int i = 0; i < 5; i++) begin
         wd = 32'h10203040 + 32'(i) * 32'h01010101;
         for (int j = 0; j < 4; j++)
            exp_wr("t3_byte", b + 4 * i + j, 10'(10'h100 + 4 * i + j), 8'(wd >> (24 - 8 * j)));
      end
      if (wq.size() >= b + 20) check("t3_span", wq[b+19].cyc - wq[b].cyc, 32'd19);

      // Overlap flag against a pending word at 0x020
      send(10'h020, 32'h11223344, 2'b10);
      chk_addr_i = 10'h01C; #1;
      check("t4_hit_1c", 32'(chk_hit_o), 32'd1);
      chk_addr_i = 10'h021; #1;
      check("t4_hit_21", 32'(chk_hit_o), 32'd1);
      chk_addr_i = 10'h024; #1;
      check("t4_miss_24", 32'(chk_hit_o), 32'd0);
      chk_addr_i = 10'h01C;
      wait_wr("t4_last", 10'h023);
      #1;
      check("t4_hit_inflight", 32'(chk_hit_o), 32'd1);
      @(negedge clock_i); #1;
      check("t4_miss_retired", 32'(chk_hit_o), 32'd0);
      check("t4_we_retired", 32'(mem_we_o), 32'd0);
      wait_idle("t4");
      chk_addr_i = 10'h000;

      // Illegal size is accepted and dropped
      b = wq.size();
      send(10'h0AA, 32'hFFFFFFFF, 2'b11);
      check("t5_err", 32'(st_err_o), 32'd1);
      check("t5_we", 32'(mem_we_o), 32'd0);
      check("t5_empty", 32'(empty_o), 32'd1);
      check("t5_ready", 32'(st_ready_o), 32'd1);
      @(negedge clock_i);
      check("t5_err_pulse", 32'(st_err_o), 32'd0);
      repeat (3) @(negedge clock_i);
      #1;
      check("t5_no_writes", 32'(wq.size() - b), 32'd0);

      // Reset during the second byte of a word
      b = wq.size();
      send(10'h040, 32'h01020304, 2'b10);
      wait_wr("t6_second", 10'h041);
      check("t6_byte1", 32'(mem_data_o), 32'h02);
      reset_i = 1'b1;
      @(negedge clock_i);
      check("t6_we", 32'(mem_we_o), 32'd0);
      check("t6_empty", 32'(empty_o), 32'd1);
      check("t6_addr", 32'(mem_addr_o), 32'd0);
      reset_i = 1'b0;
      repeat (8) @(negedge clock_i);
      #1;
      check("t6_count", 32'(wq.size() - b), 32'd2);
      exp_wr("t6_b0", b + 0, 10'h040, 8'h01);
      exp_wr("t6_b1", b + 1, 10'h041, 8'h02);
      check("t6_still_empty", 32'(empty_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
